ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER, default 8: consecutive clk_sys samples that must agree before the filtered PS/2 clock changes.
REQ-002 Parameter TIMEOUT, default 4096: maximum clk_sys cycles between filtered falling edges inside a frame.
REQ-003 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  PS/2 clock, asynchronous, idle high.
REQ-006 ps2_data  in  1  PS/2 data, asynchronous, idle high.
REQ-007 rx_byte  out  8  last correctly received byte.
REQ-008 rx_strobe  out  1  one-cycle pulse when rx_byte is updated.
REQ-009 rx_err  out  1  one-cycle pulse on parity, stop or timeout error.
REQ-010 key_code  out  8  decoded scancode without prefixes.
REQ-011 key_ext  out  1  key_code was preceded by 0xE0.
REQ-012 key_released  out  1  key_code was preceded by 0xF0.
REQ-013 key_strobe  out  1  one-cycle pulse when key_code, key_ext and key_released are updated.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-015 Filtered clock SHALL take the synchronized clock value only after FILTER consecutive equal samples; it resets to 1.
REQ-016 A falling edge SHALL be a filtered-clock transition from 1 to 0; data is sampled from the synchronized ps2_data in that cycle.
REQ-017 Frame format SHALL be: start 0, 8 data bits LSB first, odd parity, stop 1, for 11 falling edges in total.
REQ-018 FSM states SHALL be IDLE, DATA, PARITY and STOP; the reset state is IDLE.
REQ-019 In IDLE, an edge with data=0 SHALL enter DATA with bit count 0; an edge with data=1 stays in IDLE with no error.
REQ-020 In DATA, each edge SHALL shift the sampled bit into bit 7 of the shift register (right shift); after the 8th bit go to PARITY.
REQ-021 In PARITY, the edge SHALL store the parity bit and go to STOP.
REQ-022 In STOP, the edge SHALL return to IDLE; the frame is valid if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1.
REQ-023 Valid frame: rx_byte SHALL update and rx_strobe pulse in the cycle after the stop-bit edge.
REQ-024 Invalid frame: rx_err SHALL pulse at the same latency, rx_byte holds, and the prefix flags clear.
REQ-025 Timeout counter SHALL clear on every falling edge and while in IDLE, and saturate at TIMEOUT-1.
REQ-026 In a non-IDLE state, the counter reaching TIMEOUT-1 SHALL force IDLE, pulse rx_err once and clear the prefix flags.
REQ-027 If a timeout and a falling edge occur in the same cycle, the edge SHALL win and no timeout is taken.
REQ-028 Decoder on each rx_strobe: byte 0xE0 sets ext_pend; 0xF0 sets rel_pend; neither emits a key.
REQ-029 Decoder, bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: no key_strobe; both pending flags clear.
REQ-030 Decoder, any other byte: key_code=byte, key_ext=ext_pend, key_released=rel_pend, key_strobe pulses in the cycle after rx_strobe, and both pending flags clear.
REQ-031 The prefix order E0 F0 xx SHALL be accepted; F0 E0 xx SHALL yield the same flags.
REQ-032 rx_strobe and rx_err SHALL never be asserted in the same cycle.

Reset
REQ-033 Reset SHALL set all outputs, the shift register, the bit count, the timeout counter and the pending flags to 0, the filtered clock to 1, and the FSM to IDLE.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame without pulsing rx_err; the next start bit is received normally.

Verification
REQ-035 Frame 0x1C with parity 0 and stop 1, edges 200 cycles apart -> rx_byte=0x1C, one rx_strobe, key_code=0x1C, key_ext=0, key_released=0, one key_strobe.
REQ-036 Frames E0, F0, 75 -> three rx_strobe pulses, one key_strobe with key_code=0x75, key_ext=1, key_released=1.
REQ-037 Frame 0x1C with parity 1 -> one rx_err pulse, no rx_strobe, rx_byte unchanged; a following valid 0x1C is then received correctly.
REQ-038 Stop after 4 data bits, with no further edges -> rx_err pulses exactly TIMEOUT-1 cycles after the last edge and the FSM returns to IDLE; a following valid 0x29 -> rx_byte=0x29.
REQ-039 3-cycle low glitches on ps2_clk, FILTER=8 -> no state change and no strobes; reset during bit 5 -> no rx_err, all outputs 0.
REQ-040 Frames F0 then 0xFA -> no key_strobe; the next 0x1C -> key_released=0.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines, deframes
// 11-bit frames and decodes E0/F0 prefixes into key events.
module ps2_rx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk_sys_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_strobe_o,
    output logic       rx_err_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_released_o,
    output logic       key_strobe_o
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FiltMax = FW'(FILTER - 1);
    localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_strobe_q, rx_strobe_d, rx_err_q, rx_err_d;
    logic          ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d, key_rel_q, key_rel_d, key_strobe_q, key_strobe_d;

    // Glitch filter: the synchronized clock must differ from filt_q for FILTER samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FiltMax) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        rx_err_d    = 1'b0;
        abort       = 1'b0;

        if (fall || state_q == StIdle) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s2_q && ((^shift_q) ^ par_q)) begin
                        rx_byte_d   = shift_q;
                        rx_strobe_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                        abort    = 1'b1;
                    end
                end
            endcase
        end else if (state_q != StIdle && tmo_d == TmoMax) begin
            // A falling edge in the same cycle takes precedence over the timeout.
            state_d  = StIdle;
            rx_err_d = 1'b1;
            abort    = 1'b1;
        end
    end

    always_comb begin
        ext_pend_d   = ext_pend_q;
        rel_pend_d   = rel_pend_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_rel_d    = key_rel_q;
        key_strobe_d = 1'b0;
        if (abort) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else if (rx_strobe_q) begin
            unique case (rx_byte_q)
                8'hE0: ext_pend_d = 1'b1;
                8'hF0: rel_pend_d = 1'b1;
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                    ext_pend_d = 1'b0;
                    rel_pend_d = 1'b0;
                end
                default: begin
                    key_code_d   = rx_byte_q;
                    key_ext_d    = ext_pend_q;
                    key_rel_d    = rel_pend_q;
                    key_strobe_d = 1'b1;
                    ext_pend_d   = 1'b0;
                    rel_pend_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            rx_byte_q    <= '0;
            rx_strobe_q  <= 1'b0;
            rx_err_q     <= 1'b0;
            ext_pend_q   <= 1'b0;
            rel_pend_q   <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_rel_q    <= 1'b0;
            key_strobe_q <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk_i;
            clk_s2_q     <= clk_s1_q;
            data_s1_q    <= ps2_data_i;
            data_s2_q    <= data_s1_q;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            rx_byte_q    <= rx_byte_d;
            rx_strobe_q  <= rx_strobe_d;
            rx_err_q     <= rx_err_d;
            ext_pend_q   <= ext_pend_d;
            rel_pend_q   <= rel_pend_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_rel_q    <= key_rel_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign rx_byte_o      = rx_byte_q;
    assign rx_strobe_o    = rx_strobe_q;
    assign rx_err_o       = rx_err_q;
    assign key_code_o     = key_code_q;
    assign key_ext_o      = key_ext_q;
    assign key_released_o = key_rel_q;
    assign key_strobe_o   = key_strobe_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: bit-bangs PS/2 frames and checks received bytes, key events,
// error pulses and their latencies against hand-computed values.
module tb_ps2_rx;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 4096;
    localparam int EDGE_LAT = FILTER + 2;  // ps2_clk low -> output pulse visible

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte, key_code;
    logic       rx_strobe, rx_err, key_ext, key_released, key_strobe;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_low = 0;
    int strobe_cnt = 0, err_cnt = 0, key_cnt = 0, both_cnt = 0;
    int strobe_cyc = 0, err_cyc = 0;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys_i      (clk),
        .reset_i        (reset),
        .ps2_clk_i      (ps2_clk),
        .ps2_data_i     (ps2_data),
        .rx_byte_o      (rx_byte),
        .rx_strobe_o    (rx_strobe),
        .rx_err_o       (rx_err),
        .key_code_o     (key_code),
        .key_ext_o      (key_ext),
        .key_released_o (key_released),
        .key_strobe_o   (key_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Count high cycles, so a pulse stuck for two cycles shows up as a count of two.
    always @(negedge clk) begin
        if (rx_strobe) begin strobe_cnt++; strobe_cyc = cyc; end
        if (rx_err) begin err_cnt++; err_cyc = cyc; end
        if (key_strobe) key_cnt++;
        if (rx_strobe && rx_err) both_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(50);
            ps2_clk = 1'b0;
            last_low = cyc;
            wait_cyc(100);
            ps2_clk = 1'b1;
            wait_cyc(50);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(frame(d, 1'b0), 11);
        wait_cyc(20);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cyc(4);
        checks++;
        if ({rx_byte, rx_strobe, rx_err, key_code, key_ext, key_released, key_strobe} !== 21'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_byte, rx_strobe, rx_err, key_code, key_ext, key_released, key_strobe});
        else passes++;
        reset = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_single;
        int s0, k0, e0;
        s0 = strobe_cnt; k0 = key_cnt; e0 = err_cnt;
        send_byte(8'h1C);
        checks++;
        if (rx_byte !== 8'h1C) $display("FAIL single_byte: got %h expected 1c", rx_byte);
        else passes++;
        checks++;
        if (strobe_cnt - s0 !== 1) $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - s0);
        else passes++;
        checks++;
        if (strobe_cyc - last_low !== EDGE_LAT)
            $display("FAIL single_latency: got %0d expected %0d", strobe_cyc - last_low, EDGE_LAT);
        else passes++;
        checks++;
        if ({key_code, key_ext, key_released} !== {8'h1C, 2'b00})
            $display("FAIL single_key: got %h/%b/%b expected 1c/0/0", key_code, key_ext, key_released);
        else passes++;
        checks++;
        if ({key_cnt - k0, err_cnt - e0} !== {32'd1, 32'd0})
            $display("FAIL single_pulses: key %0d err %0d expected 1 0", key_cnt - k0, err_cnt - e0);
        else passes++;
    endtask

    task automatic test_prefix;
        int s0, k0;
        s0 = strobe_cnt; k0 = key_cnt;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (strobe_cnt - s0 !== 3) $display("FAIL prefix_strobes: got %0d expected 3", strobe_cnt - s0);
        else passes++;
        checks++;
        if (key_cnt - k0 !== 1) $display("FAIL prefix_keys: got %0d expected 1", key_cnt - k0);
        else passes++;
        checks++;
        if ({key_code, key_ext, key_released} !== {8'h75, 2'b11})
            $display("FAIL prefix_key: got %h/%b/%b expected 75/1/1", key_code, key_ext, key_released);
        else passes++;
    endtask

    task automatic test_parity;
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_bits(frame(8'h1C, 1'b1), 11);
        wait_cyc(20);
        checks++;
        if ({err_cnt - e0, strobe_cnt - s0} !== {32'd1, 32'd0})
            $display("FAIL parity_pulses: err %0d strobe %0d expected 1 0", err_cnt - e0, strobe_cnt - s0);
        else passes++;
        checks++;
        if (rx_byte !== 8'h75) $display("FAIL parity_hold: got %h expected 75", rx_byte);
        else passes++;
        checks++;
        if (err_cyc - last_low !== EDGE_LAT)
            $display("FAIL parity_latency: got %0d expected %0d", err_cyc - last_low, EDGE_LAT);
        else passes++;
        // An error between a prefix and its key must drop the prefix.
        send_byte(8'hE0);
        send_bits(frame(8'h1C, 1'b1), 11);
        send_byte(8'h1C);
        checks++;
        if ({rx_byte, key_code, key_ext} !== {8'h1C, 8'h1C, 1'b0})
            $display("FAIL parity_recover: got %h/%h/%b expected 1c/1c/0", rx_byte, key_code, key_ext);
        else passes++;
    endtask

    task automatic test_timeout;
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_bits(frame(8'h29, 1'b0), 5);
        wait_cyc(TIMEOUT + 100);
        checks++;
        if ({err_cnt - e0, strobe_cnt - s0} !== {32'd1, 32'd0})
            $display("FAIL timeout_pulses: err %0d strobe %0d expected 1 0", err_cnt - e0, strobe_cnt - s0);
        else passes++;
        checks++;
        if (err_cyc - last_low !== EDGE_LAT + TIMEOUT - 1)
            $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - last_low,
                     EDGE_LAT + TIMEOUT - 1);
        else passes++;
        send_byte(8'h29);
        checks++;
        if (rx_byte !== 8'h29) $display("FAIL timeout_recover: got %h expected 29", rx_byte);
        else passes++;
    endtask

    task automatic test_glitch;
        int s0, e0, k0;
        s0 = strobe_cnt; e0 = err_cnt; k0 = key_cnt;
        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        ps2_data = 1'b1;
        wait_cyc(50);
        checks++;
        if ({strobe_cnt - s0, err_cnt - e0, key_cnt - k0} !== 96'd0)
            $display("FAIL glitch_quiet: strobe %0d err %0d key %0d expected 0 0 0",
                     strobe_cnt - s0, err_cnt - e0, key_cnt - k0);
        else passes++;
        send_byte(8'h1C);
        checks++;
        if ({rx_byte, err_cnt - e0} !== {8'h1C, 32'd0})
            $display("FAIL glitch_frame: got %h err %0d expected 1c 0", rx_byte, err_cnt - e0);
        else passes++;
    endtask

    task automatic test_reset_midframe;
        int e0, s0;
        e0 = err_cnt;
        send_bits(frame(8'h5A, 1'b0), 7);
        reset = 1'b1;
        wait_cyc(3);
        checks++;
        if ({rx_byte, rx_strobe, rx_err, key_code, key_ext, key_released, key_strobe} !== 21'd0)
            $display("FAIL midreset_outputs: got %h expected 0",
                     {rx_byte, rx_strobe, rx_err, key_code, key_ext, key_released, key_strobe});
        else passes++;
        reset = 1'b0;
        wait_cyc(20);
        s0 = strobe_cnt;
        send_byte(8'h29);
        checks++;
        if ({rx_byte, strobe_cnt - s0, err_cnt - e0} !== {8'h29, 32'd1, 32'd0})
            $display("FAIL midreset_recover: got %h strobe %0d err %0d expected 29 1 0",
                     rx_byte, strobe_cnt - s0, err_cnt - e0);
        else passes++;
    endtask

    task automatic test_special;
        int k0;
        k0 = key_cnt;
        send_byte(8'hF0);
        send_byte(8'hFA);
        checks++;
        if (key_cnt - k0 !== 0) $display("FAIL special_nokey: got %0d expected 0", key_cnt - k0);
        else passes++;
        send_byte(8'h1C);
        checks++;
        if ({key_code, key_released, key_cnt - k0} !== {8'h1C, 1'b0, 32'd1})
            $display("FAIL special_clear: got %h/%b keys %0d expected 1c/0/1",
                     key_code, key_released, key_cnt - k0);
        else passes++;
    endtask

    task automatic test_back_to_back;
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++;
        if ({key_code, key_ext, key_released} !== {8'h6B, 2'b11})
            $display("FAIL f0e0_order: got %h/%b/%b expected 6b/1/1", key_code, key_ext, key_released);
        else passes++;
        checks++;
        if (both_cnt !== 0) $display("FAIL strobe_err_overlap: got %0d expected 0", both_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_special();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
